// File: rtl/vmicro16_apb_uart_tx.sv
// rtl/vmicro16_apb_uart_tx.sv - APB-attached 8N1 UART transmitter with TX FIFO and programmable baud divisor
module vmicro16_apb_uart_tx #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 434
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           S_PADDR,
   input  logic                  S_PWRITE,
   input  logic                  S_PSELx,
   input  logic                  S_PENABLE,
   input  logic [DATA_WIDTH-1:0] S_PWDATA,
   output logic [DATA_WIDTH-1:0] S_PRDATA,
   output logic                  S_PREADY,
   output logic                  uart_tx,
   output logic                  irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_next;
   logic [7:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           overflow;
   logic [15:0]    div;
   logic [15:0]    bit_cnt;
   logic [7:0]     shift;
   logic [2:0]     bit_idx;

   logic [15:0]    wdata16;
   logic [15:0]    status;
   logic           wr, push_req, push, pop, full, empty, busy, bit_end;
   logic           unused_ok;

   assign wdata16   = 16'(S_PWDATA);
   assign unused_ok = &{1'b0, S_PADDR[15:2]};

   assign S_PREADY = S_PSELx & S_PENABLE;
   assign wr       = S_PSELx & S_PENABLE & S_PWRITE;
   assign push_req = wr && (S_PADDR[1:0] == 2'd0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign push     = push_req & ~full;
   assign pop      = (state == IDLE) & ~empty;
   assign busy     = (state != IDLE);
   assign bit_end  = (bit_cnt == 16'd0);
   assign irq      = empty & (state == IDLE);

   assign status = {7'd0, 5'(count), overflow, busy, empty, full};

   always_comb begin
      S_PRDATA = '0;
      if (S_PSELx) begin
         case (S_PADDR[1:0])
            2'd1:    S_PRDATA = DATA_WIDTH'(status);
            2'd2:    S_PRDATA = DATA_WIDTH'(div);
            default: S_PRDATA = '0;
         endcase
      end
   end

   // FIFO storage needs no reset: validity is tracked entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata16[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!empty) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && bit_idx == 3'd7) state_next = STOP;
         STOP:    if (bit_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         div      <= 16'(DIV_RESET);
         bit_cnt  <= 16'd0;
         shift    <= 8'd0;
         bit_idx  <= 3'd0;
         uart_tx  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // A write into a full FIFO is lost even when a pop frees a slot this cycle.
         if (push_req && full)
            overflow <= 1'b1;
         else if (wr && S_PADDR[1:0] == 2'd1 && wdata16[3])
            overflow <= 1'b0;

         if (wr && S_PADDR[1:0] == 2'd2)
            div <= (wdata16 == 16'd0) ? 16'd1 : wdata16;

         // The bit counter is reloaded from div only at bit boundaries, so a new
         // divisor never stretches or shortens the bit already on the line.
         case (state)
            IDLE: begin
               if (!empty) begin
                  shift   <= mem[rd_ptr];
                  uart_tx <= 1'b0;
                  bit_cnt <= div - 16'd1;
               end
            end
            START: begin
               if (bit_end) begin
                  uart_tx <= shift[0];
                  shift   <= shift >> 1;
                  bit_idx <= 3'd0;
                  bit_cnt <= div - 16'd1;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     uart_tx <= 1'b1;
                  end else begin
                     uart_tx <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
                  bit_cnt <= div - 16'd1;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            STOP: begin
               if (!bit_end) bit_cnt <= bit_cnt - 16'd1;
            end
            default: uart_tx <= 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_vmicro16_apb_uart_tx.sv
// tb/tb_vmicro16_apb_uart_tx.sv - self-checking bench for vmicro16_apb_uart_tx
module tb_vmicro16_apb_uart_tx;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] paddr = '0;
   logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
   logic [15:0] pwdata = '0;
   logic [15:0] prdata;
   logic        pready, uart_tx, irq;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] tx_bytes [16];

   always #5 clk = ~clk;

   vmicro16_apb_uart_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .DIV_RESET(434)) dut (
      .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite), .S_PSELx(psel),
      .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata), .S_PREADY(pready),
      .uart_tx(uart_tx), .irq(irq)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] status_word(input int cnt, input bit busy, input bit ovf);
      int v;
      v = (cnt == DEPTH ? 1 : 0) + (cnt == 0 ? 2 : 0) + (busy ? 4 : 0) + (ovf ? 8 : 0) + cnt * 16;
      return 16'(v);
   endfunction

   // Called at a falling edge; returns at a falling edge.
   task automatic apb_write(input logic [15:0] a, input logic [15:0] d);
      psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [15:0] d, output logic rdy);
      psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1;
      d = prdata; rdy = pready;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic expect_read(input string name, input logic [15:0] a, input logic [15:0] exp);
      logic [15:0] d;
      logic        r;
      apb_read(a, d, r);
      n_cmp++;
      if (d !== exp || r !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: got data=%h ready=%b, expected data=%h ready=1", name, d, r, exp);
      end
   endtask

   task automatic wait_start(input int limit, output int waited);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Entered on the first falling edge of the start bit. Bits from frame index chg onward use d1.
   task automatic check_bits(input logic [7:0] d, input int d0, input int d1, input int chg, input bit last);
      logic exp;
      int   len, bad;
      bit   first;
      first = 1'b1;
      for (int f = 0; f < 10; f++) begin
         exp = (f == 0) ? 1'b0 : (f == 9) ? 1'b1 : d[f-1];
         len = (f < chg) ? d0 : d1;
         bad = 0;
         for (int k = 0; k < len; k++) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            if (uart_tx !== exp || irq !== 1'b0) bad++;
         end
         n_cmp++;
         if (bad != 0) begin
            n_bad++;
            $display("FAIL frame_bit%0d byte=%h: %0d of %0d samples wrong (last uart_tx=%b irq=%b, expected uart_tx=%b irq=0)",
                     f, d, bad, len, uart_tx, irq, exp);
         end
      end
      if (last) begin
         @(negedge clk);
         n_cmp++;
         if (uart_tx !== 1'b1 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_stop: got uart_tx=%b irq=%b, expected 1 1", uart_tx, irq);
         end
      end
   endtask

   task automatic check_frames(input int n, input int dv);
      int w, limit;
      limit = 12 * dv + 20;
      for (int i = 0; i < n; i++) begin
         wait_start(limit, w);
         if (uart_tx !== 1'b0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame%0d_start: got no start bit after %0d cycles, expected one", i, w);
            return;
         end
         if (i > 0) begin
            n_cmp++;
            if (w != 2) begin
               n_bad++;
               $display("FAIL frame%0d_gap: got %0d cycles to start, expected 2", i, w);
            end
         end
         check_bits(tx_bytes[i], dv, dv, 10, i == n - 1);
      end
   endtask

   task automatic test_reset;
      logic [15:0] v;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b1 || irq !== 1'b1 || prdata !== 16'h0 || pready !== 1'b0) begin
         n_bad++;
         $display("FAIL in_reset: got tx=%b irq=%b prdata=%h pready=%b, expected 1 1 0000 0", uart_tx, irq, prdata, pready);
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (uart_tx !== 1'b1 || irq !== 1'b1) begin
         n_bad++;
         $display("FAIL after_reset: got tx=%b irq=%b, expected 1 1", uart_tx, irq);
      end
      psel = 1'b1; paddr = 16'd1; penable = 1'b0; #1;
      n_cmp++;
      if (pready !== 1'b0 || prdata !== status_word(0, 0, 0)) begin
         n_bad++;
         $display("FAIL setup_phase: got pready=%b prdata=%h, expected 0 0002", pready, prdata);
      end
      @(negedge clk); psel = 1'b0;
      expect_read("reset_status", 16'd1, status_word(0, 0, 0));
      expect_read("reset_div", 16'd2, 16'd434);
      expect_read("data_reads_zero", 16'd0, 16'h0);
      v = 16'($urandom);
      apb_write(16'd3, v);
      expect_read("reserved_reads_zero", 16'd3, 16'h0);
      expect_read("reserved_write_div", 16'd2, 16'd434);
      expect_read("reserved_write_status", 16'd1, status_word(0, 0, 0));
   endtask

   task automatic test_single_frame;
      int w;
      apb_write(16'd2, 16'd4);
      expect_read("div_write", 16'd2, 16'd4);
      apb_write(16'd0, 16'h00A5);
      wait_start(20, w);
      n_cmp++;
      if (w != 1) begin
         n_bad++;
         $display("FAIL start_latency: got %0d cycles, expected 1", w);
      end
      check_bits(8'hA5, 4, 4, 10, 1'b1);
   endtask

   task automatic test_back_to_back;
      for (int r = 0; r < 3; r++) begin
         int dv, n;
         dv = $urandom_range(1, 6);
         n  = $urandom_range(2, 4);
         for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
         apb_write(16'd2, 16'(dv));
         fork
            check_frames(n, dv);
            for (int i = 0; i < n; i++) apb_write(16'd0, {8'($urandom), tx_bytes[i]});
         join
      end
   endtask

   task automatic test_div_zero;
      apb_write(16'd2, 16'd0);
      expect_read("div_zero_read", 16'd2, 16'd1);
      tx_bytes[0] = 8'($urandom);
      fork
         check_frames(1, 1);
         apb_write(16'd0, {8'h00, tx_bytes[0]});
      join
   endtask

   task automatic test_fifo_overflow;
      int accepted;
      apb_write(16'd2, 16'd100);
      for (int i = 0; i < 10; i++) tx_bytes[i] = 8'($urandom);
      fork
         check_frames(9, 100);
         begin
            // first write is popped at once; the other eight fill the FIFO, the tenth is lost
            for (int i = 0; i < 10; i++) apb_write(16'd0, {8'h00, tx_bytes[i]});
            accepted = 9;
            expect_read("overflow_status", 16'd1, status_word(accepted - 1, 1, 1));
            apb_write(16'd1, 16'h0008);
            expect_read("overflow_clear", 16'd1, status_word(accepted - 1, 1, 0));
         end
      join
      expect_read("fifo_drained", 16'd1, status_word(0, 0, 0));
   endtask

   task automatic test_reset_mid_frame;
      int w, bad;
      logic [7:0] a;
      a = 8'($urandom);
      apb_write(16'd2, 16'd4);
      apb_write(16'd0, {8'h00, a});
      wait_start(20, w);
      apb_write(16'd0, 16'($urandom));
      apb_write(16'd0, 16'($urandom));
      repeat (13) @(negedge clk);
      n_cmp++;
      if (uart_tx !== a[3]) begin
         n_bad++;
         $display("FAIL pre_reset_bit3: got %b, expected %b", uart_tx, a[3]);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (uart_tx !== 1'b1 || irq !== 1'b1) begin
         n_bad++;
         $display("FAIL async_reset: got tx=%b irq=%b, expected 1 1", uart_tx, irq);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      expect_read("post_reset_status", 16'd1, status_word(0, 0, 0));
      expect_read("post_reset_div", 16'd2, 16'd434);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL residual_frame: got %0d low samples, expected 0", bad);
      end
   endtask

   task automatic test_div_change;
      int w;
      logic [7:0] b;
      b = 8'($urandom);
      apb_write(16'd2, 16'd8);
      apb_write(16'd0, {8'h00, b});
      wait_start(20, w);
      fork
         check_bits(b, 8, 16, 4, 1'b1);
         begin
            repeat (26) @(negedge clk);
            apb_write(16'd2, 16'd16);
         end
      join
      expect_read("div_after_change", 16'd2, 16'd16);
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_back_to_back;
      test_div_zero;
      test_fifo_overflow;
      test_reset_mid_frame;
      test_div_change;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
